ifetch_prefetch: RTL

- Instruction-fetch stage directly upstream of the single-cycle core. Issues sequential word fetches to instruction memory over a valid/ready request channel and takes back in-order responses.
- Buffers fetched words in a small FIFO. Presents the head word, with its address, to the core's instruction input.
- The core redirects fetch on any taken branch, jump, trap or CSR-driven PC change. A redirect flushes the buffer and discards in-flight responses.

---
 rtl/ifetch_prefetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: issues word fetches under a credit limit,
// buffers in-order responses in a small FIFO and presents the head to the core.
module ifetch_prefetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      drop;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      tag_wr;
    logic [PTR_W-1:0]      tag_rd;

    logic [DATA_WIDTH-1:0] buf_data [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] tag_addr [DEPTH];

    logic [CNT_W:0] credit_used;
    logic           accept;
    logic           rsp_ok;
    logic           push;
    logic           pop;

    // Handshakes: a request transfers on a cycle where valid && ready; valid
    // never depends on ready, and the address is held while valid waits.
    // A response is a single-cycle valid pulse with no back-pressure.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are ignored entirely.
    assign rsp_ok = imem_rsp_valid && (outstanding != '0);
    assign push   = rsp_ok && (drop == '0) && !redirect && !reset;
    assign pop    = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else if (redirect) begin
            // A response landing in the redirect cycle is already discarded here.
            fetch_pc    <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= outstanding - CNT_W'(rsp_ok);
            drop        <= outstanding - CNT_W'(rsp_ok);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                tag_wr   <= tag_wr + 1'b1;
            end
            if (rsp_ok && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                tag_rd <= tag_rd + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({accept, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_addr[tag_wr] <= fetch_pc;
        end
        if (push) begin
            buf_data[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]   <= tag_addr[tag_rd];
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0)
    );

endmodule
